// File: rtl/ada_if_stage_if.sv
// Instruction-memory fetch port: IF drives request/address, memory returns ready/data/error.
interface ada_if_stage_if;
    logic [31:0] imem_address;
    logic        imem_request;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        imem_error;

    modport master (output imem_address, imem_request,
                    input  imem_ready, imem_data, imem_error);
    modport slave  (input  imem_address, imem_request,
                    output imem_ready, imem_data, imem_error);
endinterface

// File: rtl/ada_if_stage.sv
// ADA instruction fetch stage: PC, imem handshake, one-entry stall buffer and IF/ID register.
module ada_if_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           if_stall,
    input  logic           haz_take_branch,
    input  logic [31:0]    pc_branch_address,
    input  logic           exc_pc_load,
    input  logic [31:0]    exc_pc_address,
    ada_if_stage_if.master imem,
    output logic [31:0]    if_instruction,
    output logic [31:0]    if_pc_current,
    output logic [31:0]    if_pc_next,
    output logic           if_valid,
    output logic           exc_if_bus_error,
    output logic           exc_if_bad_pc
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic        valid;
        logic        bus_err;
        logic        bad_pc;
    } ifid_t;

    state_t      state, state_nxt;
    ifid_t       ifid, ifid_nxt;
    logic [31:0] pc, pc_nxt, pc_inc, redir_pc;
    logic [31:0] hold_data, hold_data_nxt;
    logic        hold_err, hold_err_nxt;
    logic        bad_sent, bad_sent_nxt;
    logic        redir, fire, pc_ok;

    assign redir    = exc_pc_load | (haz_take_branch & ~if_stall);
    assign redir_pc = exc_pc_load ? exc_pc_address : pc_branch_address;
    assign pc_inc   = pc + 32'd4;
    assign pc_ok    = (pc[1:0] == 2'b00);
    assign fire     = imem.imem_request & imem.imem_ready;

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        ifid_nxt      = ifid;
        hold_data_nxt = hold_data;
        hold_err_nxt  = hold_err;
        bad_sent_nxt  = bad_sent;
        if (redir) begin
            pc_nxt       = redir_pc;
            bad_sent_nxt = 1'b0;
        end
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (redir) begin
                    ifid_nxt  = '0;
                    state_nxt = (imem.imem_request && !imem.imem_ready) ? DISCARD : FETCH;
                end else if (!pc_ok) begin
                    // A misaligned PC reports once, then IF idles until redirected.
                    if (!if_stall) begin
                        ifid_nxt = bad_sent ? '0 : '{instr: 32'h0, pc: pc, pc_next: pc_inc,
                                                     valid: 1'b1, bus_err: 1'b0, bad_pc: 1'b1};
                        bad_sent_nxt = 1'b1;
                    end
                end else if (fire) begin
                    if (if_stall) begin
                        hold_data_nxt = imem.imem_data;
                        hold_err_nxt  = imem.imem_error;
                        state_nxt     = HOLD;
                    end else begin
                        ifid_nxt = '{instr: imem.imem_data, pc: pc, pc_next: pc_inc,
                                     valid: 1'b1, bus_err: imem.imem_error, bad_pc: 1'b0};
                        pc_nxt   = pc_inc;
                    end
                end else if (!if_stall) begin
                    ifid_nxt = '0;
                end
            end
            HOLD: begin
                if (redir) begin
                    ifid_nxt  = '0;
                    state_nxt = FETCH;
                end else if (!if_stall) begin
                    ifid_nxt  = '{instr: hold_data, pc: pc, pc_next: pc_inc,
                                  valid: 1'b1, bus_err: hold_err, bad_pc: 1'b0};
                    pc_nxt    = pc_inc;
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                // Wrong-path response still owed by memory; swallow it before refetching.
                if (redir || !if_stall) ifid_nxt = '0;
                if (imem.imem_ready) state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            pc                <= RESET_VECTOR;
            ifid              <= '0;
            hold_data         <= '0;
            hold_err          <= 1'b0;
            bad_sent          <= 1'b0;
            imem.imem_request <= 1'b0;
            imem.imem_address <= RESET_VECTOR;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            ifid              <= ifid_nxt;
            hold_data         <= hold_data_nxt;
            hold_err          <= hold_err_nxt;
            bad_sent          <= bad_sent_nxt;
            imem.imem_request <= (state_nxt == DISCARD) ||
                                 ((state_nxt == FETCH) && (pc_nxt[1:0] == 2'b00));
            if (state_nxt != DISCARD) imem.imem_address <= pc_nxt;
        end
    end

    assign if_instruction   = ifid.instr;
    assign if_pc_current    = ifid.pc;
    assign if_pc_next       = ifid.pc_next;
    assign if_valid         = ifid.valid;
    assign exc_if_bus_error = ifid.bus_err;
    assign exc_if_bad_pc    = ifid.bad_pc;
endmodule

// File: tb/tb_ada_if_stage.sv
// Bench for ada_if_stage: directed scenarios, then random traffic against an in-order stream scoreboard.
module tb_ada_if_stage;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, if_stall, haz_take_branch, exc_pc_load;
    logic [31:0] pc_branch_address, exc_pc_address;
    logic [31:0] if_instruction, if_pc_current, if_pc_next;
    logic        if_valid, exc_if_bus_error, exc_if_bad_pc;
    int          n_chk = 0, n_err = 0;

    ada_if_stage_if imem();

    ada_if_stage #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .if_stall(if_stall), .haz_take_branch(haz_take_branch),
        .pc_branch_address(pc_branch_address), .exc_pc_load(exc_pc_load),
        .exc_pc_address(exc_pc_address), .imem(imem),
        .if_instruction(if_instruction), .if_pc_current(if_pc_current),
        .if_pc_next(if_pc_next), .if_valid(if_valid),
        .exc_if_bus_error(exc_if_bus_error), .exc_if_bad_pc(exc_if_bad_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[7:2] == 6'h2D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic quiet();
        rst = 1'b0; if_stall = 1'b0; haz_take_branch = 1'b0; exc_pc_load = 1'b0;
        imem.imem_ready = 1'b0; imem.imem_data = '0; imem.imem_error = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d, input logic e);
        imem.imem_ready = 1'b1; imem.imem_data = d; imem.imem_error = e;
    endtask

    // Leaves the DUT one cycle past reset, first request just issued.
    task automatic do_reset();
        quiet(); rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    task automatic load_n(input int n);
        for (int i = 0; i < n; i++) begin
            respond(mem_word(imem.imem_address), 1'b0); tick();
        end
        quiet();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_pc, prev_addr;
        logic        prev_pending;
        int          consumed;

        quiet(); pc_branch_address = '0; exc_pc_address = '0;
        rst = 1'b1; tick(); tick();
        chk("rst_req", imem.imem_request, 0);
        chk("rst_addr", imem.imem_address, RV);
        chk("rst_valid", if_valid, 0);
        chk("rst_instr", if_instruction, 0);
        chk("rst_pc", if_pc_current, 0);
        chk("rst_flags", {exc_if_bus_error, exc_if_bad_pc}, 0);

        // zero-wait memory; ready during IDLE must be ignored
        rst = 1'b0; respond(mem_word(imem.imem_address), 1'b0); tick();
        chk("first_req", imem.imem_request, 1);
        chk("first_addr", imem.imem_address, RV);
        chk("idle_valid", if_valid, 0);
        for (int i = 0; i < 3; i++) begin
            respond(mem_word(imem.imem_address), 1'b0); tick();
            chk("zw_pc", if_pc_current, RV + 4 * i);
            chk("zw_next", if_pc_next, RV + 4 * i + 4);
            chk("zw_valid", if_valid, 1);
            chk("zw_instr", if_instruction, mem_word(RV + 4 * i));
        end

        // stall in the cycle the response returns
        do_reset(); load_n(1);
        if_stall = 1'b1; respond(32'hDEADBEEF, 1'b0); tick();
        chk("stall_pc", if_pc_current, RV);
        chk("stall_req", imem.imem_request, 0);
        imem.imem_ready = 1'b0; tick(); tick();
        chk("hold_pc", if_pc_current, RV);
        chk("hold_instr", if_instruction, mem_word(RV));
        if_stall = 1'b0; tick();
        chk("rel_instr", if_instruction, 32'hDEADBEEF);
        chk("rel_pc", if_pc_current, RV + 4);
        chk("rel_next", if_pc_next, RV + 8);
        chk("rel_addr", imem.imem_address, RV + 8);
        chk("rel_req", imem.imem_request, 1);

        // branch while a request is outstanding
        do_reset(); load_n(4);
        haz_take_branch = 1'b1; pc_branch_address = 32'h40; tick();
        chk("br_req", imem.imem_request, 1);
        chk("br_addr", imem.imem_address, 32'h10);
        chk("br_valid", if_valid, 0);
        haz_take_branch = 1'b0; tick();
        chk("disc_addr", imem.imem_address, 32'h10);
        respond(32'hBAD0_0010, 1'b0); tick();
        chk("disc_drop", if_valid, 0);
        chk("disc_next", imem.imem_address, 32'h40);
        respond(mem_word(32'h40), 1'b0); tick();
        chk("br_tgt_pc", if_pc_current, 32'h40);
        chk("br_tgt_instr", if_instruction, mem_word(32'h40));

        // exception while stalled
        quiet(); if_stall = 1'b1; exc_pc_load = 1'b1; exc_pc_address = 32'h80; tick();
        chk("exc_flush", if_valid, 0);
        quiet(); respond(32'h5555_0044, 1'b0); tick();
        chk("exc_addr", imem.imem_address, 32'h80);
        chk("exc_req", imem.imem_request, 1);
        chk("exc_valid", if_valid, 0);

        // bus error, then misaligned branch target
        respond(mem_word(32'h80), 1'b1); tick();
        chk("berr_valid", if_valid, 1);
        chk("berr_flag", exc_if_bus_error, 1);
        quiet(); haz_take_branch = 1'b1; pc_branch_address = 32'h42;
        respond(32'h7777_0084, 1'b0); tick();
        chk("bad_noreq", imem.imem_request, 0);
        quiet(); tick();
        chk("bad_valid", if_valid, 1);
        chk("bad_flag", exc_if_bad_pc, 1);
        chk("bad_pc", if_pc_current, 32'h42);
        chk("bad_instr", if_instruction, 0);
        tick();
        chk("bad_wait", imem.imem_request, 0);

        // reset mid-request with a late response
        exc_pc_load = 1'b1; exc_pc_address = 32'h100; tick();
        chk("rfe_addr", imem.imem_address, 32'h100);
        chk("rfe_req", imem.imem_request, 1);
        quiet(); tick();
        rst = 1'b1; tick();
        chk("mid_rst_req", imem.imem_request, 0);
        chk("mid_rst_addr", imem.imem_address, RV);
        rst = 1'b0; respond(32'hBADB_AD00, 1'b0); tick();
        chk("late_valid", if_valid, 0);
        chk("late_addr", imem.imem_address, RV);
        chk("late_req", imem.imem_request, 1);
        respond(mem_word(RV), 1'b0); tick();
        chk("post_rst_pc", if_pc_current, RV);
        chk("post_rst_valid", if_valid, 1);

        // random traffic: every consumed entry must be the next PC of the program stream
        do_reset();
        exp_pc = RV; prev_pending = 1'b0; prev_addr = '0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (if_valid) begin
                chk("r_instr", if_instruction, mem_word(if_pc_current));
                chk("r_next", if_pc_next, if_pc_current + 32'd4);
                chk("r_berr", exc_if_bus_error, mem_err(if_pc_current));
                chk("r_badpc", exc_if_bad_pc, 0);
            end else begin
                chk("r_bubble", if_instruction, 0);
            end
            if (prev_pending) begin
                chk("r_req_held", imem.imem_request, 1);
                chk("r_addr_held", imem.imem_address, prev_addr);
            end
            quiet();
            if_stall          = ($urandom_range(0, 3) == 0);
            haz_take_branch   = ($urandom_range(0, 9) == 0);
            pc_branch_address = 32'h100 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            exc_pc_load       = ($urandom_range(0, 24) == 0);
            exc_pc_address    = 32'h800 + {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            if (imem.imem_request && $urandom_range(0, 9) < 6)
                respond(mem_word(imem.imem_address), mem_err(imem.imem_address));
            if (!if_stall && !exc_pc_load && if_valid) begin
                chk("r_seq_pc", if_pc_current, exp_pc);
                exp_pc = if_pc_current + 32'd4;
                consumed++;
            end
            if (exc_pc_load) exp_pc = exc_pc_address;
            else if (haz_take_branch && !if_stall) exp_pc = pc_branch_address;
            prev_pending = imem.imem_request && !imem.imem_ready;
            prev_addr    = imem.imem_address;
            tick();
        end
        chk("r_progress", 32'(consumed >= 300), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/ada_if_stage.md
Name: ada_if_stage

Overview:
- Instruction Fetch stage of the ADA 5-stage pipeline.
- Owns the PC register, drives the instruction memory request/ready handshake and loads the IF/ID pipeline register consumed by the decode stage (instruction, pc_current, pc_next).
- Handles ID stalls with a one-entry hold buffer, branch redirects from ID, and exception redirects from the exception unit.
- Squashes wrong-path fetches, including responses that are still in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- if_stall  input  1  ID/hazard stall; hold the IF/ID register and the PC.
- haz_take_branch  input  1  branch taken in ID; redirect to pc_branch_address.
- pc_branch_address  input  32  branch target from ID.
- exc_pc_load  input  1  exception/RFE redirect; flush IF/ID.
- exc_pc_address  input  32  exception vector or return address.
- imem_address  output  32  fetch address, word aligned.
- imem_request  output  1  fetch request; held with a stable address until imem_ready.
- imem_ready  input  1  response valid this cycle.
- imem_data  input  32  instruction word.
- imem_error  input  1  bus error on this response; qualified by imem_ready.
- if_instruction  output  32  to ID; 32'h0 (NOP) when if_valid=0.
- if_pc_current  output  32  address of if_instruction.
- if_pc_next  output  32  if_pc_current + 4.
- if_valid  output  1  IF/ID holds a real instruction.
- exc_if_bus_error  output  1  fetch bus error attached to the IF/ID entry.
- exc_if_bad_pc  output  1  misaligned PC attached to the IF/ID entry.

Behaviour:
- Reset values:
  - pc=RESET_VECTOR; state=IDLE.
  - imem_request=0; imem_address=RESET_VECTOR.
  - All IF/ID outputs 0, exc flags 0.
  - rst mid-transaction abandons any outstanding request; a late imem_ready after reset is ignored while in IDLE.
- States: IDLE, FETCH, HOLD, DISCARD.
  - IDLE: imem_request=0; next cycle goes to FETCH. Reset-to-first-request latency is 1 cycle.
  - FETCH: imem_request=1, imem_address=pc.
    - On imem_ready with no redirect and if_stall=0: load IF/ID (instruction=imem_data, pc_current=pc, pc_next=pc+4, valid=1, bus_error=imem_error); pc<=pc+4; stay in FETCH. Back-to-back single-cycle responses give 1 instr/cycle.
    - On imem_ready with if_stall=1: capture the response in the hold buffer; go to HOLD; imem_request=0.
    - No imem_ready and if_stall=0: IF/ID loads a bubble (valid=0, instruction=0).
  - HOLD: no request. When if_stall falls, the buffer moves to IF/ID, pc<=pc+4, and the state returns to FETCH.
  - DISCARD: a request was outstanding when a redirect occurred. Keep imem_request=1 at the old address until imem_ready, drop the data, then go to FETCH at the new pc.
- Redirect priority: rst > exc_pc_load > haz_take_branch > sequential.
  - exc_pc_load: pc<=exc_pc_address; IF/ID cleared to bubble regardless of if_stall; hold buffer dropped.
  - haz_take_branch: applied only when if_stall=0. pc<=pc_branch_address. The instruction fetched in the same cycle is squashed (no delay slot) and IF/ID loads a bubble.
  - If imem_ready arrives in the redirect cycle, the response is dropped and the FSM goes straight to FETCH. Otherwise, with a request outstanding, the FSM goes to DISCARD.
  - A redirect in DISCARD overwrites pc; the state stays in DISCARD.
- Misaligned pc ([1:0]!=0) in FETCH:
  - No memory request is issued.
  - When not stalled, IF/ID loads valid=1, instruction=0, exc_if_bad_pc=1, pc_current=pc.
  - The FSM then waits in FETCH with no request until a redirect arrives.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 without a flag.
- imem_address changes only when no request is pending or in the cycle after imem_ready.

Test Plan:
- Reset then zero-wait memory: imem_ready=1 every cycle from 0x0 -> request at cycle 1; IF/ID pc_current = 0x0, 0x4, 0x8 on consecutive cycles; pc_next = pc_current+4; valid=1.
- Stall during response: if_stall=1 in the cycle imem_ready returns 0x00000004's word 0xDEADBEEF -> IF/ID unchanged and request drops. Releasing stall 3 cycles later presents 0xDEADBEEF at pc 0x4, and the next fetch address is 0x8.
- Branch with outstanding request: request to 0x10 pending, haz_take_branch with target 0x40 -> request held at 0x10 until ready; that data never appears (valid=0); next request 0x40.
- Exception during stall: if_stall=1 with a valid entry, exc_pc_load with vector 0x80 -> IF/ID becomes bubble next cycle; next request 0x80.
- Errors: imem_error=1 on ready -> exc_if_bus_error=1 with valid=1. A branch to 0x42 -> no request; exc_if_bad_pc=1, pc_current=0x42.
- Reset mid-wait: rst while request pending, late imem_ready arrives -> ignored; first new request at RESET_VECTOR.
